// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bundle between bus masters and bus_arbiter.
// The URGENT/URGENT_ID signals exist only when BUS_ARB_URGENT_EN is defined.
interface bus_arbiter_if #(parameter int CNT_W = 5);
  logic [7:0]       REQ;
  logic [7:0]       GNT;
  logic [2:0]       SEL;
  logic             BUS_VALID;
  logic [CNT_W-1:0] HOLD_CNT;
`ifdef BUS_ARB_URGENT_EN
  logic             URGENT;
  logic [2:0]       URGENT_ID;
  modport master (output REQ, URGENT, URGENT_ID, input GNT, SEL, BUS_VALID, HOLD_CNT);
  modport slave  (input REQ, URGENT, URGENT_ID, output GNT, SEL, BUS_VALID, HOLD_CNT);
`else
  modport master (output REQ, input GNT, SEL, BUS_VALID, HOLD_CNT);
  modport slave  (input REQ, output GNT, SEL, BUS_VALID, HOLD_CNT);
`endif
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: 8-master round-robin arbiter with tenure limit and bubble-free handover.
// Optional BUS_ARB_URGENT_EN adds URGENT/URGENT_ID preemption.
module bus_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input logic CLK,
  input logic RST,
  bus_arbiter_if.slave bus
);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d, last_q, last_d, win, pick;
  logic             valid_q, valid_d, expired, sat, take;
  logic [CNT_W-1:0] hold_q, hold_d;
  // Scanning from offset 8 down to 1 leaves the nearest requester after LAST; the owner itself comes last.
  always_comb begin
    win = last_q;
    for (int i = 8; i >= 1; i--)
      win = bus.REQ[3'(last_q + 3'(i))] ? 3'(last_q + 3'(i)) : win;
  end
  assign expired = (MAX_HOLD != 0) && (hold_q == CNT_W'(MAX_HOLD - 1));
  assign sat     = (MAX_HOLD != 0) ? (hold_q == CNT_W'(MAX_HOLD)) : &hold_q;
`ifdef BUS_ARB_URGENT_EN
  logic urg;
  assign urg  = bus.URGENT && bus.REQ[bus.URGENT_ID];
  assign pick = urg ? bus.URGENT_ID : win;
  assign take = urg || state_q == IDLE || !bus.REQ[sel_q] || expired;
`else
  assign pick = win;
  assign take = state_q == IDLE || !bus.REQ[sel_q] || expired;
`endif
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    last_d  = last_q;
    hold_d  = (state_q == OWNED && !sat) ? hold_q + 1'b1 : hold_q;
    if (take && |bus.REQ) begin
      state_d = OWNED;
      gnt_d   = N_REQ'(1) << pick;
      sel_d   = pick;
      valid_d = 1'b1;
      last_d  = pick;
      hold_d  = '0;
    end else if (take) begin
      state_d = IDLE;
      gnt_d   = '0;
      valid_d = 1'b0;
      hold_d  = '0;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 3'd7;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end
  assign bus.GNT       = gnt_q;
  assign bus.SEL       = sel_q;
  assign bus.BUS_VALID = valid_q;
  assign bus.HOLD_CNT  = hold_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of bus_arbiter with MAX_HOLD=16 (a16) and MAX_HOLD=4 (a4).
// Both instances see the same REQ and reset.
module tb_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.CNT_W(5)) a16 ();
  bus_arbiter_if #(.CNT_W(5)) a4 ();
  assign a16.REQ = req;
  assign a4.REQ  = req;
`ifdef BUS_ARB_URGENT_EN
  assign a16.URGENT = 1'b0;
  assign a16.URGENT_ID = 3'd0;
  assign a4.URGENT = 1'b0;
  assign a4.URGENT_ID = 3'd0;
`endif

  bus_arbiter #(.N_REQ(8), .MAX_HOLD(16), .CNT_W(5)) dut16 (.CLK(clk), .RST(rst), .bus(a16.slave));
  bus_arbiter #(.N_REQ(8), .MAX_HOLD(4),  .CNT_W(5)) dut4  (.CLK(clk), .RST(rst), .bus(a4.slave));

  always @(posedge clk) if (!rst) assert (!$isunknown(req));

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (a16.GNT !== 8'h00 || a16.SEL !== 3'd0 || a16.BUS_VALID !== 1'b0 || a16.HOLD_CNT !== 5'd0) begin
        errors++;
        $display("FAIL reset_idle c=%0d got gnt=%h sel=%0d v=%b hold=%0d exp gnt=00 sel=0 v=0 hold=0",
                 c, a16.GNT, a16.SEL, a16.BUS_VALID, a16.HOLD_CNT);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h04;
    @(negedge clk);
    checks++;
    if (a16.GNT !== 8'h04 || a16.SEL !== 3'd2 || a16.BUS_VALID !== 1'b1 || a16.HOLD_CNT !== 5'd0) begin
      errors++;
      $display("FAIL single_grant got gnt=%h sel=%0d v=%b hold=%0d exp gnt=04 sel=2 v=1 hold=0",
               a16.GNT, a16.SEL, a16.BUS_VALID, a16.HOLD_CNT);
    end
    req = 8'h00;
    @(negedge clk);
    checks++;
    if (a16.GNT !== 8'h00 || a16.SEL !== 3'd2 || a16.BUS_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_release got gnt=%h sel=%0d v=%b exp gnt=00 sel=2 v=0",
               a16.GNT, a16.SEL, a16.BUS_VALID);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] own;
    do_reset();
    req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      own = 3'((c / 4) % 8);
      checks++;
      if (a4.GNT !== (8'h01 << own) || a4.SEL !== own || a4.BUS_VALID !== 1'b1 || a4.HOLD_CNT !== 5'(c % 4)) begin
        errors++;
        $display("FAIL round_robin c=%0d got gnt=%h sel=%0d v=%b hold=%0d exp owner=%0d hold=%0d v=1",
                 c, a4.GNT, a4.SEL, a4.BUS_VALID, a4.HOLD_CNT, own, c % 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 8'h08;
    repeat (3) @(negedge clk);
    checks++;
    if (a16.GNT !== 8'h08 || a16.HOLD_CNT !== 5'd2) begin
      errors++;
      $display("FAIL handover_owner got gnt=%h hold=%0d exp gnt=08 hold=2", a16.GNT, a16.HOLD_CNT);
    end
    req = 8'h20;
    @(negedge clk);
    checks++;
    if (a16.GNT !== 8'h20 || a16.SEL !== 3'd5 || a16.BUS_VALID !== 1'b1 || a16.HOLD_CNT !== 5'd0) begin
      errors++;
      $display("FAIL handover_next got gnt=%h sel=%0d v=%b hold=%0d exp gnt=20 sel=5 v=1 hold=0",
               a16.GNT, a16.SEL, a16.BUS_VALID, a16.HOLD_CNT);
    end
    // Owner 5 releases while 0 and 2 wait: search from 6 wraps to master 0.
    req = 8'h05;
    @(negedge clk);
    checks++;
    if (a16.GNT !== 8'h01 || a16.SEL !== 3'd0 || a16.BUS_VALID !== 1'b1) begin
      errors++;
      $display("FAIL handover_wrap got gnt=%h sel=%0d v=%b exp gnt=01 sel=0 v=1",
               a16.GNT, a16.SEL, a16.BUS_VALID);
    end
    req = 8'h04;
    @(negedge clk);
    checks++;
    if (a16.GNT !== 8'h04 || a16.SEL !== 3'd2 || a16.BUS_VALID !== 1'b1) begin
      errors++;
      $display("FAIL handover_third got gnt=%h sel=%0d v=%b exp gnt=04 sel=2 v=1",
               a16.GNT, a16.SEL, a16.BUS_VALID);
    end
  endtask

  task automatic test_lone_expiry();
    do_reset();
    req = 8'h01;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (a16.GNT !== 8'h01 || a16.BUS_VALID !== 1'b1 || a16.HOLD_CNT !== 5'(c % 16)) begin
        errors++;
        $display("FAIL lone_expiry c=%0d got gnt=%h v=%b hold=%0d exp gnt=01 v=1 hold=%0d",
                 c, a16.GNT, a16.BUS_VALID, a16.HOLD_CNT, c % 16);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h40;
    repeat (2) @(negedge clk);
    checks++;
    if (a16.GNT !== 8'h40 || a16.SEL !== 3'd6) begin
      errors++;
      $display("FAIL async_owner got gnt=%h sel=%0d exp gnt=40 sel=6", a16.GNT, a16.SEL);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a16.GNT !== 8'h00 || a16.SEL !== 3'd0 || a16.BUS_VALID !== 1'b0 || a16.HOLD_CNT !== 5'd0) begin
      errors++;
      $display("FAIL async_clear got gnt=%h sel=%0d v=%b hold=%0d exp all zero",
               a16.GNT, a16.SEL, a16.BUS_VALID, a16.HOLD_CNT);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 8'h41;
    @(negedge clk);
    checks++;
    if (a16.GNT !== 8'h01 || a16.SEL !== 3'd0 || a16.BUS_VALID !== 1'b1) begin
      errors++;
      $display("FAIL async_restart got gnt=%h sel=%0d v=%b exp gnt=01 sel=0 v=1",
               a16.GNT, a16.SEL, a16.BUS_VALID);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_lone_expiry();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
